// File: rtl/reg_dump.sv
// Register-file dump engine: walks FIRST_REG..LAST_REG through one read port and streams each value out on a valid/ready port.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last data beat.
module reg_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_last,
    output logic        dump_csum
);

    localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SEND, FIN} state_t;
`endif

    state_t      state_reg;
    logic [4:0]  ptr_reg;
    logic        done_reg;
    logic        valid_reg;
    logic        last_reg;
    logic [4:0]  addr_reg;
    logic [31:0] data_reg;
`ifdef REG_DUMP_CHECKSUM_EN
    logic        csum_reg;
    logic [31:0] acc_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= FIRST_ADDR;
            done_reg  <= 1'b0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            addr_reg  <= 5'd0;
            data_reg  <= 32'd0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_reg  <= 1'b0;
            acc_reg   <= 32'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    ptr_reg <= FIRST_ADDR;
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_reg <= 32'd0;
`endif
                    if (start) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    // rd_data reflects the register contents before any write landing on this same edge
                    data_reg  <= rd_data;
                    addr_reg  <= ptr_reg;
                    valid_reg <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_reg   <= acc_reg ^ rd_data;
                    last_reg  <= 1'b0;
`else
                    last_reg  <= (ptr_reg == LAST_ADDR);
`endif
                    state_reg <= SEND;
                end
                SEND: begin
                    if (valid_reg && dump_ready) begin
                        valid_reg <= 1'b0;
                        if (ptr_reg == LAST_ADDR) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            valid_reg <= 1'b1;
                            data_reg  <= acc_reg;
                            addr_reg  <= 5'd0;
                            csum_reg  <= 1'b1;
                            last_reg  <= 1'b1;
                            state_reg <= CSUM;
`else
                            done_reg  <= 1'b1;
                            state_reg <= FIN;
`endif
                        end else begin
                            ptr_reg   <= ptr_reg + 5'd1;
                            state_reg <= LOAD;
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (dump_ready) begin
                        valid_reg <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= FIN;
                    end
                end
`endif
                FIN: begin
                    done_reg  <= 1'b0;
                    last_reg  <= 1'b0;
                    ptr_reg   <= FIRST_ADDR;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_reg  <= 1'b0;
`endif
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign rd_addr    = ptr_reg;
    assign dump_valid = valid_reg;
    assign dump_addr  = addr_reg;
    assign dump_data  = data_reg;
    assign dump_last  = last_reg;
`ifdef REG_DUMP_CHECKSUM_EN
    assign dump_csum  = csum_reg;
`else
    assign dump_csum  = 1'b0;
`endif

endmodule
